// File: rtl/instr_encoder.sv
// Control-bundle to 16-bit instruction encoder with legality check.
// Streams legal words into instruction memory at an auto-incrementing address.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] aluop;
        logic       reg2loc;
        logic       regwrite;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
    } ctrl_t;

    // Reference opcode decoder; opcode = {aluop, memwrite, memread}
    function automatic ctrl_t ref_decode(input logic [3:0] op);
        ctrl_t d;
        d.aluop    = op[3:2];
        d.memwrite = op[1];
        d.memread  = op[0];
        d.branch   = op[2];
        d.reg2loc  = op[2] | op[1];
        d.regwrite = op[3] | op[0];
        d.alusrc   = op[1] | op[0];
        d.memtoreg = op[0];
        return d;
    endfunction

endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_aluop,
    input  logic              in_reg2loc,
    input  logic              in_regwrite,
    input  logic              in_alusrc,
    input  logic              in_branch,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic              in_memtoreg,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

    state_t      state;
    logic        stage_valid;
    logic [15:0] stage_word;

    ctrl_t       ctrl;
    logic [3:0]  opcode;
    logic        legal;
    logic        accept;
    logic        wr_done;
    logic        at_max;
    logic        start;
    logic        last_wr;

    assign ctrl = {in_aluop, in_reg2loc, in_regwrite, in_alusrc,
                   in_branch, in_memread, in_memwrite, in_memtoreg};

    assign opcode  = {in_aluop, in_memwrite, in_memread};
    assign legal   = (ctrl == ref_decode(opcode));
    assign at_max  = (imem_addr == MAX_ADDR);
    assign wr_done = stage_valid & imem_ready;
    assign last_wr = wr_done & at_max;
    assign start   = (state == IDLE) & prog_start;

    // A word staged for the last address ends the session, so hold off new bundles
    assign in_ready = (state == LOAD) &
                      (~stage_valid | (imem_ready & ~at_max));

    assign accept     = in_valid & in_ready;
    assign imem_we    = stage_valid;
    assign imem_wdata = stage_word;

    // Session control: IDLE/LOAD/DRAIN, done pulse and sticky full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            full  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (prog_start) begin
                        state <= LOAD;
                        full  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept && in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!stage_valid) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (last_wr) begin
                full  <= 1'b1;
                done  <= 1'b1;
                state <= IDLE;
            end
        end
    end

    // Single-entry output stage feeding the memory write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_word  <= '0;
        end else if (last_wr) begin
            stage_valid <= 1'b0;
        end else if (accept && legal) begin
            stage_valid <= 1'b1;
            stage_word  <= {opcode, in_rd, in_rn, in_rm};
        end else if (wr_done) begin
            stage_valid <= 1'b0;
        end
    end

    // Write address: rewinds on session start, advances per completed write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr <= BASE_ADDR;
        end else if (start) begin
            imem_addr <= BASE_ADDR;
        end else if (wr_done && !at_max) begin
            imem_addr <= imem_addr + ADDR_W'(1);
        end
    end

    // Illegal-bundle flag and saturating counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else if (start) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else if (accept && !legal) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
